// File: rtl/ibex_rf_cache_pkg.sv
// Shared types for the cached Ibex register file: fill FSM states and the L1 entry layout.
package ibex_rf_cache_pkg;

    localparam int unsigned TagW    = 5;
    // Widest DataWidth the L1 entry can hold; narrower registers are zero-extended.
    localparam int unsigned RfDataW = 32;

    typedef enum logic [1:0] {
        RF_IDLE,
        RF_FILL_A,
        RF_FILL_B
    } rf_fill_e;

    typedef struct packed {
        logic               valid;
        logic [TagW-1:0]    tag;
        logic [RfDataW-1:0] data;
    } rf_l1_entry_t;

endpackage

// File: rtl/ibex_rf_cache_lookup.sv
// Combinational tag CAM over the L1 entries; returns hit and the index of the matching entry.
module ibex_rf_cache_lookup
    import ibex_rf_cache_pkg::*;
#(
    parameter int unsigned  L1Entries = 8,
    localparam int unsigned IdxW      = $clog2(L1Entries)
) (
    input  logic [L1Entries-1:0]           valid_i,
    input  logic [L1Entries-1:0][TagW-1:0] tag_i,
    input  logic [TagW-1:0]                addr_i,
    output logic                           hit_o,
    output logic [IdxW-1:0]                idx_o
);

    // At most one entry matches, so OR-ing indices yields the matching one.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = 0; i < L1Entries; i++) begin
            if (valid_i[i] && (tag_i[i] == addr_i)) begin
                hit_o = 1'b1;
                idx_o = idx_o | IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/ibex_rf_cached.sv
// Two-level Ibex register file: fully-associative flop L1 in front of an external 2-port SRAM L2.
module ibex_rf_cached
    import ibex_rf_cache_pkg::*;
#(
    parameter bit          RV32E             = 1'b0,
    parameter int unsigned DataWidth         = 32,
    parameter int unsigned L1Entries         = 8,
    parameter bit          DummyInstructions = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 dummy_instr_id_i,
    input  logic [4:0]           raddr_a_i,
    input  logic                 ren_a_i,
    output logic [DataWidth-1:0] rdata_a_o,
    input  logic [4:0]           raddr_b_i,
    input  logic                 ren_b_i,
    output logic [DataWidth-1:0] rdata_b_o,
    input  logic [4:0]           waddr_a_i,
    input  logic [DataWidth-1:0] wdata_a_i,
    input  logic                 we_a_i,
    input  logic                 invalidate_i,
    output logic                 stall_o,
    output logic                 perf_miss_o,
    output logic [4:0]           sram_raddr_o,
    output logic                 sram_re_o,
    input  logic [DataWidth-1:0] sram_rdata_i,
    output logic [4:0]           sram_waddr_o,
    output logic                 sram_we_o,
    output logic [DataWidth-1:0] sram_wdata_o
);

    localparam int unsigned IdxW = $clog2(L1Entries);

    function automatic logic is_x0(input logic [4:0] a);
        return (a == 5'd0) || (RV32E && a[4]);
    endfunction

    rf_l1_entry_t                   entries_q [L1Entries];
    rf_l1_entry_t                   entries_d [L1Entries];
    logic [L1Entries-1:0]           valid_vec;
    logic [L1Entries-1:0][TagW-1:0] tag_vec;
    logic [IdxW-1:0]                ptr_q, ptr_d;
    rf_fill_e                       state_q, state_d;
    logic [4:0]                     fill_addr_q, fill_addr_d;
    logic                           kill_q, kill_d;
    logic                           byp_vld_q, byp_vld_d;
    logic [DataWidth-1:0]           byp_data_q;
    logic [DataWidth-1:0]           fill_data, r0_data;
    logic                           ra_zero, rb_zero, wr_en;
    logic                           fwd_a, fwd_b, miss_a, miss_b;
    logic                           hit_a, hit_b, hit_w;
    logic [IdxW-1:0]                idx_a, idx_b, idx_w;
    logic                           stall, sram_re, fill_en, fill_live, wr_merge;

    always_comb begin
        valid_vec = '0;
        tag_vec   = '0;
        for (int i = 0; i < L1Entries; i++) begin
            valid_vec[i] = entries_q[i].valid;
            tag_vec[i]   = entries_q[i].tag;
        end
    end

    ibex_rf_cache_lookup #(.L1Entries(L1Entries)) u_lookup_a (
        .valid_i(valid_vec), .tag_i(tag_vec), .addr_i(raddr_a_i), .hit_o(hit_a), .idx_o(idx_a)
    );
    ibex_rf_cache_lookup #(.L1Entries(L1Entries)) u_lookup_b (
        .valid_i(valid_vec), .tag_i(tag_vec), .addr_i(raddr_b_i), .hit_o(hit_b), .idx_o(idx_b)
    );
    ibex_rf_cache_lookup #(.L1Entries(L1Entries)) u_lookup_w (
        .valid_i(valid_vec), .tag_i(tag_vec), .addr_i(waddr_a_i), .hit_o(hit_w), .idx_o(idx_w)
    );

    assign ra_zero = is_x0(raddr_a_i);
    assign rb_zero = is_x0(raddr_b_i);
    assign wr_en   = we_a_i && !is_x0(waddr_a_i);
    assign fwd_a   = wr_en && !ra_zero && (waddr_a_i == raddr_a_i);
    assign fwd_b   = wr_en && !rb_zero && (waddr_a_i == raddr_b_i);
    assign miss_a  = ren_a_i && !ra_zero && !hit_a && !fwd_a;
    assign miss_b  = ren_b_i && !rb_zero && !hit_b && !fwd_b;

    if (DummyInstructions) begin : g_dummy_r0
        logic [DataWidth-1:0] rf_r0_q;
        always_ff @(posedge clk_i) begin
            if (we_a_i && dummy_instr_id_i) begin
                rf_r0_q <= wdata_a_i;
            end
        end
        assign r0_data = dummy_instr_id_i ? rf_r0_q : '0;
    end else begin : g_no_dummy_r0
        logic unused_dummy_instr;
        assign unused_dummy_instr = dummy_instr_id_i;
        assign r0_data            = '0;
    end

    always_comb begin
        rdata_a_o = entries_q[idx_a].data[DataWidth-1:0];
        if (fwd_a)   rdata_a_o = wdata_a_i;
        if (ra_zero) rdata_a_o = r0_data;
        rdata_b_o = entries_q[idx_b].data[DataWidth-1:0];
        if (fwd_b)   rdata_b_o = wdata_a_i;
        if (rb_zero) rdata_b_o = r0_data;
    end

    always_comb begin
        state_d      = state_q;
        fill_addr_d  = fill_addr_q;
        sram_raddr_o = fill_addr_q;
        sram_re      = 1'b0;
        stall        = 1'b0;
        perf_miss_o  = 1'b0;
        fill_en      = 1'b0;
        unique case (state_q)
            RF_IDLE: begin
                if (miss_a) begin
                    stall        = 1'b1;
                    sram_re      = 1'b1;
                    sram_raddr_o = raddr_a_i;
                    fill_addr_d  = raddr_a_i;
                    state_d      = RF_FILL_A;
                end else if (miss_b) begin
                    stall        = 1'b1;
                    sram_re      = 1'b1;
                    sram_raddr_o = raddr_b_i;
                    fill_addr_d  = raddr_b_i;
                    state_d      = RF_FILL_B;
                end
            end
            RF_FILL_A: begin
                stall       = 1'b1;
                perf_miss_o = 1'b1;
                fill_en     = 1'b1;
                state_d     = RF_IDLE;
                // B lands in the entry A is filling when the addresses match.
                if (miss_b && (raddr_b_i != raddr_a_i)) begin
                    sram_re      = 1'b1;
                    sram_raddr_o = raddr_b_i;
                    fill_addr_d  = raddr_b_i;
                    state_d      = RF_FILL_B;
                end
            end
            RF_FILL_B: begin
                stall       = 1'b1;
                perf_miss_o = 1'b1;
                fill_en     = 1'b1;
                state_d     = RF_IDLE;
            end
            default: state_d = RF_IDLE;
        endcase
    end

    assign stall_o      = stall && rst_ni;
    assign sram_re_o    = sram_re && rst_ni;
    assign sram_we_o    = wr_en;
    assign sram_waddr_o = waddr_a_i;
    assign sram_wdata_o = wdata_a_i;

    // A fill overlapping an invalidate must not resurrect a valid entry.
    assign kill_d    = (state_d != RF_IDLE) && (kill_q || invalidate_i);
    assign byp_vld_d = sram_re && wr_en && (sram_raddr_o == waddr_a_i);
    assign fill_data = byp_vld_q ? byp_data_q : sram_rdata_i;
    assign fill_live = fill_en && !kill_q;
    assign wr_merge  = fill_live && wr_en && (waddr_a_i == fill_addr_q);

    always_comb begin
        entries_d = entries_q;
        ptr_d     = ptr_q;
        if (fill_live) begin
            entries_d[ptr_q] = '{valid: 1'b1, tag: fill_addr_q,
                                 data: RfDataW'(wr_merge ? wdata_a_i : fill_data)};
            ptr_d = ptr_q + 1'b1;
        end
        if (wr_en && !wr_merge) begin
            if (hit_w) begin
                // A hit on the entry the fill is evicting is dropped; L2 still takes the write.
                if (!(fill_live && (idx_w == ptr_q))) begin
                    entries_d[idx_w].data = RfDataW'(wdata_a_i);
                end
            end else begin
                entries_d[ptr_d] = '{valid: 1'b1, tag: waddr_a_i, data: RfDataW'(wdata_a_i)};
                ptr_d            = ptr_d + 1'b1;
            end
        end
        if (invalidate_i) begin
            for (int i = 0; i < L1Entries; i++) begin
                entries_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RF_IDLE;
            fill_addr_q <= '0;
            kill_q      <= 1'b0;
            byp_vld_q   <= 1'b0;
            ptr_q       <= '0;
            for (int i = 0; i < L1Entries; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            kill_q      <= kill_d;
            byp_vld_q   <= byp_vld_d;
            ptr_q       <= ptr_d;
            entries_q   <= entries_d;
        end
    end

    always_ff @(posedge clk_i) begin
        byp_data_q <= wdata_a_i;
    end

    a_fill_a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == RF_FILL_A) |-> (raddr_a_i == fill_addr_q));
    a_fill_b_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == RF_FILL_B) |-> (raddr_b_i == fill_addr_q));

endmodule

// File: tb/tb_ibex_rf_cached.sv
// Directed cycle-table bench for ibex_rf_cached (L1Entries=4) with a behavioural 2-port SRAM.
module tb_ibex_rf_cached;

    typedef struct {
        logic [4:0]  ra;
        logic        ena;
        logic [4:0]  rb;
        logic        enb;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        we;
        logic        inv;
        logic        x_stall;
        logic        x_sre;
        logic [4:0]  x_sraddr;
        logic        x_perf;
        logic        x_swe;
        logic        ca;
        logic [31:0] xa;
        logic        cb;
        logic [31:0] xb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        dummy_instr;
    logic [4:0]  raddr_a, raddr_b, waddr_a;
    logic        ren_a, ren_b, we_a, invalidate;
    logic [31:0] rdata_a, rdata_b, wdata_a;
    logic        stall, perf_miss;
    logic [4:0]  sram_raddr, sram_waddr;
    logic        sram_re, sram_we;
    logic [31:0] sram_rdata, sram_wdata;
    logic [31:0] mem [32];

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    ibex_rf_cached #(
        .RV32E(1'b0), .DataWidth(32), .L1Entries(4), .DummyInstructions(1'b0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .dummy_instr_id_i(dummy_instr),
        .raddr_a_i(raddr_a), .ren_a_i(ren_a), .rdata_a_o(rdata_a),
        .raddr_b_i(raddr_b), .ren_b_i(ren_b), .rdata_b_o(rdata_b),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .invalidate_i(invalidate), .stall_o(stall), .perf_miss_o(perf_miss),
        .sram_raddr_o(sram_raddr), .sram_re_o(sram_re), .sram_rdata_i(sram_rdata),
        .sram_waddr_o(sram_waddr), .sram_we_o(sram_we), .sram_wdata_o(sram_wdata)
    );

    always @(posedge clk) begin
        if (sram_we) mem[sram_waddr] <= sram_wdata;
        if (sram_re) sram_rdata <= mem[sram_raddr];
    end

    function automatic logic [31:0] l2v(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] wv(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic add(input int ra, input int ena, input int rb, input int enb,
                       input int wa, input logic [31:0] wd, input int we, input int inv,
                       input int st, input int sre, input int sa, input int pf, input int swe,
                       input int ca, input logic [31:0] xa, input int cb, input logic [31:0] xb);
        vec_t v;
        v.ra = 5'(ra);  v.ena = (ena != 0); v.rb = 5'(rb); v.enb = (enb != 0);
        v.wa = 5'(wa);  v.wd = wd; v.we = (we != 0); v.inv = (inv != 0);
        v.x_stall = (st != 0); v.x_sre = (sre != 0); v.x_sraddr = 5'(sa);
        v.x_perf = (pf != 0); v.x_swe = (swe != 0);
        v.ca = (ca != 0); v.xa = xa; v.cb = (cb != 0); v.xb = xb;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        raddr_a = v.ra; ren_a = v.ena; raddr_b = v.rb; ren_b = v.enb;
        waddr_a = v.wa; wdata_a = v.wd; we_a = v.we; invalidate = v.inv;
    endtask

    task automatic idle_inputs();
        raddr_a = 5'd0; ren_a = 1'b0; raddr_b = 5'd0; ren_b = 1'b0;
        waddr_a = 5'd0; wdata_a = 32'd0; we_a = 1'b0; invalidate = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        dummy_instr = 1'b0;
        idle_inputs();
        for (int i = 0; i < 32; i++) mem[i] <= l2v(i);

        // cold single miss on A
        add(5,1,0,0, 0,32'd0,0,0, 1,1,5,0,0, 0,32'd0,0,32'd0);
        add(5,1,0,0, 0,32'd0,0,0, 1,0,0,1,0, 0,32'd0,0,32'd0);
        add(5,1,0,0, 0,32'd0,0,0, 0,0,0,0,0, 1,l2v(5),0,32'd0);
        // double miss A=x3, B=x7
        add(3,1,7,1, 0,32'd0,0,0, 1,1,3,0,0, 0,32'd0,0,32'd0);
        add(3,1,7,1, 0,32'd0,0,0, 1,1,7,1,0, 0,32'd0,0,32'd0);
        add(3,1,7,1, 0,32'd0,0,0, 1,0,0,1,0, 0,32'd0,0,32'd0);
        add(3,1,7,1, 0,32'd0,0,0, 0,0,0,0,0, 1,l2v(3),1,l2v(7));
        // write x9 with same-cycle forwarded read, then hit
        add(9,1,0,0, 9,32'hDEADBEEF,1,0, 0,0,0,0,1, 1,32'hDEADBEEF,0,32'd0);
        add(9,1,0,0, 0,32'd0,0,0, 0,0,0,0,0, 1,32'hDEADBEEF,0,32'd0);
        // write x1..x5 into a 4-entry L1
        for (int i = 1; i <= 5; i++) add(0,0,0,0, i,wv(i),1,0, 0,0,0,0,1, 0,32'd0,0,32'd0);
        add(1,1,2,1, 0,32'd0,0,0, 1,1,1,0,0, 0,32'd0,1,wv(2));
        add(1,1,2,1, 0,32'd0,0,0, 1,0,0,1,0, 0,32'd0,0,32'd0);
        add(1,1,2,0, 0,32'd0,0,0, 0,0,0,0,0, 1,wv(1),0,32'd0);
        // fill of x6 merged with a same-cycle write of x6
        add(6,1,0,0, 0,32'd0,0,0, 1,1,6,0,0, 0,32'd0,0,32'd0);
        add(6,1,0,0, 6,32'h1234,1,0, 1,0,0,1,1, 1,32'h1234,0,32'd0);
        add(6,1,0,0, 0,32'd0,0,0, 0,0,0,0,0, 1,32'h1234,0,32'd0);
        // fill of x8 with a same-cycle write-allocate of x10
        add(8,1,0,0, 0,32'd0,0,0, 1,1,8,0,0, 0,32'd0,0,32'd0);
        add(8,1,0,0, 10,32'hABCD,1,0, 1,0,0,1,1, 0,32'd0,0,32'd0);
        add(8,1,10,1, 0,32'd0,0,0, 0,0,0,0,0, 1,l2v(8),1,32'hABCD);
        // invalidate, then x8 misses again
        add(0,0,0,0, 0,32'd0,0,1, 0,0,0,0,0, 0,32'd0,0,32'd0);
        add(8,1,0,0, 0,32'd0,0,0, 1,1,8,0,0, 0,32'd0,0,32'd0);
        add(8,1,0,0, 0,32'd0,0,0, 1,0,0,1,0, 0,32'd0,0,32'd0);
        add(8,1,0,0, 0,32'd0,0,0, 0,0,0,0,0, 1,l2v(8),0,32'd0);
        // x0 reads and write to x0; unused operand never misses
        add(0,1,0,1, 0,32'hFFFFFFFF,1,0, 0,0,0,0,0, 1,32'd0,1,32'd0);
        add(20,0,21,0, 0,32'd0,0,0, 0,0,0,0,0, 0,32'd0,0,32'd0);
        // miss on B only
        add(0,0,13,1, 0,32'd0,0,0, 1,1,13,0,0, 0,32'd0,0,32'd0);
        add(0,0,13,1, 0,32'd0,0,0, 1,0,0,1,0, 0,32'd0,0,32'd0);
        add(0,0,13,1, 0,32'd0,0,0, 0,0,0,0,0, 0,32'd0,1,l2v(13));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", -1, 32'(stall), 32'd0);
        chk("reset_perf",  -1, 32'(perf_miss), 32'd0);
        chk("reset_sre",   -1, 32'(sram_re), 32'd0);
        chk("reset_swe",   -1, 32'(sram_we), 32'd0);
        rst_ni = 1'b1;

        foreach (tbl[r]) begin
            @(posedge clk);
            #1;
            drive(tbl[r]);
            #1;
            chk("stall", r, 32'(stall), 32'(tbl[r].x_stall));
            chk("sram_re", r, 32'(sram_re), 32'(tbl[r].x_sre));
            chk("perf_miss", r, 32'(perf_miss), 32'(tbl[r].x_perf));
            chk("sram_we", r, 32'(sram_we), 32'(tbl[r].x_swe));
            if (tbl[r].x_sre) chk("sram_raddr", r, 32'(sram_raddr), 32'(tbl[r].x_sraddr));
            if (tbl[r].ca) chk("rdata_a", r, rdata_a, tbl[r].xa);
            if (tbl[r].cb) chk("rdata_b", r, rdata_b, tbl[r].xb);
        end

        // reset pulsed in the middle of a fill
        @(posedge clk);
        #1;
        idle_inputs();
        raddr_a = 5'd12; ren_a = 1'b1;
        #1;
        chk("rst_fill_stall0", 100, 32'(stall), 32'd1);
        chk("rst_fill_raddr", 100, 32'(sram_raddr), 32'd12);
        @(posedge clk);
        #2;
        chk("rst_fill_perf", 101, 32'(perf_miss), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_stall", 102, 32'(stall), 32'd0);
        chk("rst_mid_perf",  102, 32'(perf_miss), 32'd0);
        chk("rst_mid_sre",   102, 32'(sram_re), 32'd0);
        @(posedge clk);
        #1;
        ren_a = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        raddr_a = 5'd8; ren_a = 1'b1;
        #1;
        chk("post_rst_stall", 103, 32'(stall), 32'd1);
        chk("post_rst_sre",   103, 32'(sram_re), 32'd1);
        chk("post_rst_raddr", 103, 32'(sram_raddr), 32'd8);
        @(posedge clk);
        #2;
        chk("post_rst_perf", 104, 32'(perf_miss), 32'd1);
        @(posedge clk);
        #2;
        chk("post_rst_hit_stall", 105, 32'(stall), 32'd0);
        chk("post_rst_rdata", 105, rdata_a, l2v(8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
